// File: rtl/ftdi_packet_engine.sv
// ============================================================================
//  Module      : ftdi_packet_engine
//  Description : Collects PKT_LEN words over the RX four-phase handshake,
//                transforms each word and echoes the packet over TX.
//                Optional macro FTDI_PKT_CHECKSUM_EN appends a modulo-sum word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ftdi_packet_engine #(
   parameter int                DATA_W     = 8,
   parameter int                PKT_LEN    = 5,
   parameter logic [DATA_W-1:0] MATCH_WORD = DATA_W'('hAA),
   parameter int                MODE       = 1
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic [DATA_W-1:0] in_rx_data,
   input  logic              in_rx_hsk_req,
   output logic              out_rx_hsk_ack,
   output logic              out_rx_en,
   output logic [DATA_W-1:0] out_tx_data,
   input  logic              in_tx_hsk_ack,
   output logic              out_tx_hsk_req,
   output logic              out_busy,
   output logic [7:0]        out_pkt_cnt
);

   localparam int IDX_W = $clog2(PKT_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RX_ACK  = 3'd1,
      S_TX_LOAD = 3'd2,
      S_TX_REQ  = 3'd3,
      S_TX_WAIT = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
   logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
   logic [7:0]        pkt_cnt_q, pkt_cnt_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [DATA_W-1:0] buf_q [PKT_LEN];
   logic [DATA_W-1:0] buf_d [PKT_LEN];
   logic [DATA_W-1:0] rd_word;
`ifdef FTDI_PKT_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              sum_phase_q, sum_phase_d;
`endif

   function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] w);
      case (MODE)
         0:       xform = w;
         1:       xform = (w == MATCH_WORD) ? ~w : w;
         default: xform = ~w;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      rx_idx_d  = rx_idx_q;
      tx_idx_d  = tx_idx_q;
      pkt_cnt_d = pkt_cnt_q;
      tx_data_d = tx_data_q;
      buf_d     = buf_q;
`ifdef FTDI_PKT_CHECKSUM_EN
      sum_d       = sum_q;
      sum_phase_d = sum_phase_q;
`endif
      // Compare-based read mux keeps the index width independent of PKT_LEN
      rd_word = '0;
      for (int i = 0; i < PKT_LEN; i++) begin
         if (tx_idx_q == IDX_W'(i)) rd_word = buf_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (in_rx_hsk_req) begin
               for (int i = 0; i < PKT_LEN; i++) begin
                  if (rx_idx_q == IDX_W'(i)) buf_d[i] = in_rx_data;
               end
               rx_idx_d = rx_idx_q + 1'b1;
               state_d  = S_RX_ACK;
            end
         end
         S_RX_ACK: begin
            if (!in_rx_hsk_req) begin
               if (rx_idx_q == IDX_W'(PKT_LEN)) begin
                  rx_idx_d = '0;
                  state_d  = S_TX_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_TX_LOAD: begin
`ifdef FTDI_PKT_CHECKSUM_EN
            if (sum_phase_q) begin
               tx_data_d = sum_q;
            end else begin
               tx_data_d = xform(rd_word);
               sum_d     = sum_q + xform(rd_word);
            end
`else
            tx_data_d = xform(rd_word);
`endif
            state_d = S_TX_REQ;
         end
         S_TX_REQ: begin
            if (in_tx_hsk_ack) begin
               state_d = S_TX_WAIT;
`ifdef FTDI_PKT_CHECKSUM_EN
               if (!sum_phase_q) tx_idx_d = tx_idx_q + 1'b1;
`else
               tx_idx_d = tx_idx_q + 1'b1;
`endif
            end
         end
         S_TX_WAIT: begin
            if (!in_tx_hsk_ack) begin
               if (tx_idx_q != IDX_W'(PKT_LEN)) begin
                  state_d = S_TX_LOAD;
               end else begin
`ifdef FTDI_PKT_CHECKSUM_EN
                  // Data words done: one more pass through TX_LOAD for the sum
                  if (!sum_phase_q) begin
                     sum_phase_d = 1'b1;
                     state_d     = S_TX_LOAD;
                  end else begin
                     sum_phase_d = 1'b0;
                     sum_d       = '0;
                     tx_idx_d    = '0;
                     pkt_cnt_d   = pkt_cnt_q + 8'd1;
                     state_d     = S_IDLE;
                  end
`else
                  tx_idx_d  = '0;
                  pkt_cnt_d = pkt_cnt_q + 8'd1;
                  state_d   = S_IDLE;
`endif
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q   <= S_IDLE;
         rx_idx_q  <= '0;
         tx_idx_q  <= '0;
         pkt_cnt_q <= '0;
         tx_data_q <= '0;
`ifdef FTDI_PKT_CHECKSUM_EN
         sum_q       <= '0;
         sum_phase_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         rx_idx_q  <= rx_idx_d;
         tx_idx_q  <= tx_idx_d;
         pkt_cnt_q <= pkt_cnt_d;
         tx_data_q <= tx_data_d;
`ifdef FTDI_PKT_CHECKSUM_EN
         sum_q       <= sum_d;
         sum_phase_q <= sum_phase_d;
`endif
      end
   end

   // Packet storage needs no reset: every slot is written before it is read
   always_ff @(posedge in_clk) begin
      buf_q <= buf_d;
   end

   assign out_rx_en      = (state_q == S_IDLE);
   assign out_rx_hsk_ack = (state_q == S_RX_ACK);
   assign out_tx_hsk_req = (state_q == S_TX_REQ);
   assign out_busy       = (state_q != S_IDLE);
   assign out_tx_data    = tx_data_q;
   assign out_pkt_cnt    = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ftdi_packet_engine.sv
// ============================================================================
//  Module      : tb_ftdi_packet_engine
//  Description : Directed self-checking bench; instance A is MODE=1/PKT_LEN=5,
//                instance B is MODE=0/PKT_LEN=1. Honours FTDI_PKT_CHECKSUM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ftdi_packet_engine;

   logic       clk = 1'b0;
   logic       rst;
   int         n_total = 0;
   int         n_bad   = 0;

   logic [7:0] a_rx_data, a_tx_data, a_cnt;
   logic       a_rx_req, a_rx_ack, a_rx_en, a_tx_ack, a_tx_req, a_busy;
   logic [7:0] b_rx_data, b_tx_data, b_cnt;
   logic       b_rx_req, b_rx_ack, b_rx_en, b_tx_ack, b_tx_req, b_busy;

   logic [7:0] vin  [5];
   logic [7:0] vout [5];

   always #5 clk = ~clk;

   ftdi_packet_engine #(.DATA_W(8), .PKT_LEN(5), .MATCH_WORD(8'hAA), .MODE(1)) u_a (
      .in_clk(clk), .in_rst(rst),
      .in_rx_data(a_rx_data), .in_rx_hsk_req(a_rx_req),
      .out_rx_hsk_ack(a_rx_ack), .out_rx_en(a_rx_en),
      .out_tx_data(a_tx_data), .in_tx_hsk_ack(a_tx_ack),
      .out_tx_hsk_req(a_tx_req), .out_busy(a_busy), .out_pkt_cnt(a_cnt)
   );

   ftdi_packet_engine #(.DATA_W(8), .PKT_LEN(1), .MATCH_WORD(8'hAA), .MODE(0)) u_b (
      .in_clk(clk), .in_rst(rst),
      .in_rx_data(b_rx_data), .in_rx_hsk_req(b_rx_req),
      .out_rx_hsk_ack(b_rx_ack), .out_rx_en(b_rx_en),
      .out_tx_data(b_tx_data), .in_tx_hsk_ack(b_tx_ack),
      .out_tx_hsk_req(b_tx_req), .out_busy(b_busy), .out_pkt_cnt(b_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tmo(input string tag);
      n_total++;
      n_bad++;
      $display("FAIL %s timeout got=0 exp=1", tag);
   endtask

   task automatic a_send(input logic [7:0] w);
      int n;
      n = 0;
      while (a_rx_en !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (a_rx_en !== 1'b1) tmo("a_rx_en");
      a_rx_data = w;
      a_rx_req  = 1'b1;
      n = 0;
      while (a_rx_ack !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (a_rx_ack !== 1'b1) tmo("a_rx_ack_hi");
      a_rx_req = 1'b0;
      n = 0;
      while (a_rx_ack !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      if (a_rx_ack !== 1'b0) tmo("a_rx_ack_lo");
   endtask

   task automatic a_recv(input string tag, input logic [7:0] exp, input int dly, input bit pulse);
      int n;
      bit ok;
      n = 0;
      while (a_tx_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (a_tx_req !== 1'b1) tmo({tag, "_req"});
      chk(tag, a_tx_data, exp);
      ok = 1'b1;
      for (int k = 0; k < dly; k++) begin
         if (pulse) a_rx_req = (k >= 2 && k < 5);
         @(negedge clk);
         if (a_tx_req !== 1'b1 || a_tx_data !== exp || a_rx_ack !== 1'b0) ok = 1'b0;
      end
      a_rx_req = 1'b0;
      if (dly > 0) chk({tag, "_hold"}, {31'd0, ok}, 32'd1);
      a_tx_ack = 1'b1;
      n = 0;
      while (a_tx_req !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      if (a_tx_req !== 1'b0) tmo({tag, "_req_lo"});
      a_tx_ack = 1'b0;
      @(negedge clk);
   endtask

   // Sends vin[], expects vout[] (and cs in checksum builds); cnt_prev is the count before.
   task automatic a_roundtrip(input string tag, input logic [7:0] cs, input int dly,
                              input bit pulse, input logic [7:0] cnt_prev);
      for (int i = 0; i < 5; i++) a_send(vin[i]);
      for (int i = 0; i < 5; i++) a_recv($sformatf("%s_w%0d", tag, i), vout[i], dly, pulse);
`ifdef FTDI_PKT_CHECKSUM_EN
      chk({tag, "_cnt_pre_cs"}, a_cnt, cnt_prev);
      a_recv({tag, "_cs"}, cs, dly, 1'b0);
`else
      chk({tag, "_cs_unused"}, cs, cs);
`endif
      chk({tag, "_idle"}, a_busy, 1'b0);
      chk({tag, "_cnt"}, a_cnt, cnt_prev + 8'd1);
   endtask

   task automatic b_tx_word(input string tag, input logic [7:0] exp);
      int n;
      n = 0;
      while (b_tx_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (b_tx_req !== 1'b1) tmo({tag, "_req"});
      chk(tag, b_tx_data, exp);
      b_tx_ack = 1'b1;
      @(negedge clk);
      chk({tag, "_req_drop"}, b_tx_req, 1'b0);
      b_tx_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      a_rx_data = '0; a_rx_req = 1'b0; a_tx_ack = 1'b0;
      b_rx_data = '0; b_rx_req = 1'b0; b_tx_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_rx_en",   a_rx_en,   1'b1);
      chk("rst_busy",    a_busy,    1'b0);
      chk("rst_rx_ack",  a_rx_ack,  1'b0);
      chk("rst_tx_req",  a_tx_req,  1'b0);
      chk("rst_cnt",     a_cnt,     8'd0);
      chk("rst_tx_data", a_tx_data, 8'd0);
      chk("rst_b_cnt",   b_cnt,     8'd0);

      // MODE 1: AA words are inverted
      vin  = '{8'h01, 8'hAA, 8'h02, 8'hAA, 8'h03};
      vout = '{8'h01, 8'h55, 8'h02, 8'h55, 8'h03};
      a_roundtrip("m1", 8'hB0, 0, 1'b0, 8'd0);

      // PKT_LEN=1 exact timing
      b_rx_data = 8'h7E;
      b_rx_req  = 1'b1;
      @(negedge clk);
      chk("b_rx_ack_1cyc", b_rx_ack, 1'b1);
      b_rx_req = 1'b0;
      @(negedge clk);
      chk("b_tx_load", {b_busy, b_tx_req}, 2'b10);
      b_tx_word("b_w0", 8'h7E);
`ifdef FTDI_PKT_CHECKSUM_EN
      b_tx_word("b_cs", 8'h7E);
`endif
      chk("b_idle_1cyc", b_busy, 1'b0);
      chk("b_cnt", b_cnt, 8'd1);

      // Slow TX acknowledge with RX requests pulsed while busy
      vin  = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'hAA};
      vout = '{8'h55, 8'h55, 8'h00, 8'hFF, 8'h55};
      a_roundtrip("slow", 8'hFE, 10, 1'b1, 8'd1);

      // Reset after 3 of 5 words discards the partial packet
      a_send(8'h20);
      a_send(8'h21);
      a_send(8'h22);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy",  a_busy,  1'b0);
      chk("mid_rst_rx_en", a_rx_en, 1'b1);
      chk("mid_rst_cnt",   a_cnt,   8'd0);
      vin  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      vout = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      a_roundtrip("after_rst", 8'h5A, 0, 1'b0, 8'd0);

      vin  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      vout = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      a_roundtrip("sum", 8'h0F, 0, 1'b0, 8'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
